main_dec: RTL and testbench



---
 rtl/main_dec.sv | 80 ++++++++
 tb/tb_main_dec.sv | 104 ++++++++++
 2 files changed

// File: rtl/main_dec.sv
// LEGv8 main control decoder: 11-bit opcode to datapath controls, one registered
// cycle of latency, with a valid qualifier and an illegal-opcode flag.
module main_dec #(
  parameter int OP_W = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [OP_W-1:0] Op,
  output logic            out_valid,
  output logic            Reg2Loc,
  output logic            ALUSrc,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic [1:0]      ALUOp,
  output logic            illegal
);

  // Packed control word: {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}
  logic [8:0] ctrl_s;
  logic       illegal_s;
  logic [8:0] ctrl_r;
  logic       illegal_r;
  logic       valid_r;

  // Opcode decode; unknown opcodes become a no-op and raise illegal
  always_comb begin
    ctrl_s    = 9'b0_0_0_0_0_0_0_00;
    illegal_s = 1'b0;
    if (in_valid) begin
      if (Op[10:3] == 8'b10110100) begin
        ctrl_s = 9'b1_0_0_0_0_0_1_01;
      end else begin
        case (Op)
          11'b11111000010: ctrl_s = 9'b0_1_1_1_1_0_0_00;
          11'b11111000000: ctrl_s = 9'b1_1_0_0_0_1_0_00;
          11'b10001011000,
          11'b11001011000,
          11'b10001010000,
          11'b10101010000: ctrl_s = 9'b0_0_0_1_0_0_0_10;
          default: begin
            ctrl_s    = 9'b0_0_0_0_0_0_0_00;
            illegal_s = 1'b1;
          end
        endcase
      end
    end else begin
      ctrl_s    = 9'b0_0_0_0_0_0_0_00;
      illegal_s = 1'b0;
    end
  end

  // Output register; reset drops any decode in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_r    <= 9'b0_0_0_0_0_0_0_00;
      illegal_r <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      ctrl_r    <= ctrl_s;
      illegal_r <= illegal_s;
      valid_r   <= in_valid;
    end
  end

  assign out_valid = valid_r;
  assign illegal   = illegal_r;
  assign Reg2Loc   = ctrl_r[8];
  assign ALUSrc    = ctrl_r[7];
  assign MemtoReg  = ctrl_r[6];
  assign RegWrite  = ctrl_r[5];
  assign MemRead   = ctrl_r[4];
  assign MemWrite  = ctrl_r[3];
  assign Branch    = ctrl_r[2];
  assign ALUOp     = ctrl_r[1:0];

endmodule

// File: tb/tb_main_dec.sv
// Directed bench for main_dec: expected control words are queued as stimulus is
// driven and compared one cycle later when the registered outputs settle.
module tb_main_dec;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [10:0] Op = 11'b0;
  logic        out_valid, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, illegal;
  logic [1:0]  ALUOp;

  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];

  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ0 = 11'b10110100010;
  localparam logic [10:0] CBZ1 = 11'b10110100011;
  localparam logic [10:0] ADDo = 11'b10001011000;
  localparam logic [10:0] SUBo = 11'b11001011000;
  localparam logic [10:0] ANDo = 11'b10001010000;
  localparam logic [10:0] ORRo = 11'b10101010000;

  main_dec #(.OP_W(11)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .Op(Op),
    .out_valid(out_valid), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .ALUOp(ALUOp), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference: {out_valid, illegal, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}
  function automatic logic [10:0] model(input logic rst_n, input logic v, input logic [10:0] op);
    if (!rst_n || !v)                 return 11'b00_000000000;
    if (op == LDUR)                   return 11'b10_011110000;
    if (op == STUR)                   return 11'b10_110001000;
    if (op[10:3] == 8'b10110100)      return 11'b10_100000101;
    if (op == ADDo || op == SUBo || op == ANDo || op == ORRo)
                                      return 11'b10_000100010;
    return 11'b11_000000000;
  endfunction

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one input cycle, then compare the registered result after the edge
  task automatic cycle(input logic rst_n, input logic v, input logic [10:0] op, input string tag);
    logic [10:0] exp;
    logic [10:0] obs;
    reset    = rst_n;
    in_valid = v;
    Op       = op;
    exp_q.push_back(model(rst_n, v, op));
    @(posedge clk);
    @(negedge clk);
    exp = exp_q.pop_front();
    obs = {out_valid, illegal, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp};
    check(tag, obs, exp);
    check({tag, "_rd_wr"}, {10'b0, MemRead & MemWrite}, 11'b0);
    check({tag, "_rw_wr"}, {10'b0, RegWrite & MemWrite}, 11'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    cycle(1'b0, 1'b1, LDUR, "rst0");
    cycle(1'b0, 1'b1, LDUR, "rst1");
    cycle(1'b1, 1'b1, LDUR, "ldur_after_rst");
    cycle(1'b1, 1'b1, STUR, "stur");
    cycle(1'b1, 1'b1, CBZ0, "cbz0");
    cycle(1'b1, 1'b1, CBZ1, "cbz1");
    cycle(1'b1, 1'b1, ADDo, "add");
    cycle(1'b1, 1'b1, SUBo, "sub");
    cycle(1'b1, 1'b1, ANDo, "and");
    cycle(1'b1, 1'b1, ORRo, "orr");
    cycle(1'b1, 1'b1, 11'b11111111111, "ill_ones");
    cycle(1'b1, 1'b1, 11'b00000000000, "ill_zeros");
    cycle(1'b1, 1'b1, LDUR, "ldur_clears_ill");
    cycle(1'b1, 1'b0, ADDo, "bubble");
    cycle(1'b1, 1'b1, STUR, "stur_pre_rst");
    cycle(1'b0, 1'b1, ADDo, "mid_rst");
    cycle(1'b1, 1'b1, 11'b10110100111, "cbz7");
    cycle(1'b1, 1'b1, 11'b10110101000, "near_cbz");
    cycle(1'b1, 1'b1, 11'b11111000011, "near_ldur");
    for (int i = 0; i < 2048; i++) begin
      cycle(1'b1, 1'b1, 11'(i), $sformatf("sweep_%0d", i));
    end
    check("queue_empty", 11'(exp_q.size()), 11'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
